// File: rtl/img_pkg.sv
// Shared constants, command encodings and helpers for the 8x8 image buffer.
package img_pkg;

    localparam int PIX_W   = 8;
    localparam int ADDR_W  = 6;
    localparam int IMG_DIM = 8;
    localparam int NPIX    = IMG_DIM * IMG_DIM;
    localparam int POS_W   = 3;

    localparam logic [POS_W-1:0] POS_MIN  = 3'd1;
    localparam logic [POS_W-1:0] POS_MAX  = 3'd7;
    localparam logic [POS_W-1:0] POS_INIT = 3'd4;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_AVG   = 3'd5;
    localparam logic [2:0] CMD_MIRX  = 3'd6;
    localparam logic [2:0] CMD_MIRY  = 3'd7;

    // Linear pixel index y*8+x.
    function automatic logic [ADDR_W-1:0] pix_idx(input logic [POS_W-1:0] x,
                                                  input logic [POS_W-1:0] y);
        return {y, x};
    endfunction

    // Floor of the mean of four pixels using a 10-bit sum.
    function automatic logic [PIX_W-1:0] avg4(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c,
                                              input logic [PIX_W-1:0] d);
        logic [PIX_W+1:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[PIX_W+1:2];
    endfunction

endpackage

// File: rtl/img_regfile.sv
// 64x8 pixel store: one load write port, a four-pixel read/update port, one readout port.
module img_regfile
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] ra0_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    input  logic [ADDR_W-1:0] ra3_i,
    output logic [PIX_W-1:0]  rd0_o,
    output logic [PIX_W-1:0]  rd1_o,
    output logic [PIX_W-1:0]  rd2_o,
    output logic [PIX_W-1:0]  rd3_o,
    input  logic              upd_en_i,
    input  logic [PIX_W-1:0]  ud0_i,
    input  logic [PIX_W-1:0]  ud1_i,
    input  logic [PIX_W-1:0]  ud2_i,
    input  logic [PIX_W-1:0]  ud3_i,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [PIX_W-1:0]  rb_data_o
);

    logic [PIX_W-1:0] mem_q [NPIX];

    // Pixel storage; the load write port wins over a block update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else if (upd_en_i) begin
            mem_q[ra0_i] <= ud0_i;
            mem_q[ra1_i] <= ud1_i;
            mem_q[ra2_i] <= ud2_i;
            mem_q[ra3_i] <= ud3_i;
        end
    end

    assign rd0_o     = mem_q[ra0_i];
    assign rd1_o     = mem_q[ra1_i];
    assign rd2_o     = mem_q[ra2_i];
    assign rd3_o     = mem_q[ra3_i];
    assign rb_data_o = mem_q[rb_addr_i];

endmodule

// File: rtl/img_buf.sv
// Image buffer: IROM load, IRB readout, operation point and 2x2 block commands.
module img_buf
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              irb_rw,
    input  logic              cmd_en,
    input  logic [2:0]        cmd,
    input  logic [PIX_W-1:0]  IROM_Q,
    output logic [ADDR_W-1:0] IROM_A,
    output logic [ADDR_W-1:0] IRB_A,
    output logic [PIX_W-1:0]  IRB_D,
    output logic              write
);

    logic [POS_W-1:0]  px_q, px_d, py_q, py_d;
    logic [ADDR_W-1:0] acnt_q, acnt_d;
    logic [ADDR_W-1:0] aprev_q;
    logic              load_d_q;

    logic [ADDR_W-1:0] a_tl_s, a_tr_s, a_bl_s, a_br_s;
    logic [PIX_W-1:0]  r_tl_s, r_tr_s, r_bl_s, r_br_s;
    logic [PIX_W-1:0]  u_tl_s, u_tr_s, u_bl_s, u_br_s;
    logic [PIX_W-1:0]  avg_s;
    logic              upd_en_s;
    logic              pix_blocked_s;
    logic [PIX_W-1:0]  rb_data_s;

    assign a_tl_s = pix_idx(px_q - 3'd1, py_q - 3'd1);
    assign a_tr_s = pix_idx(px_q,        py_q - 3'd1);
    assign a_bl_s = pix_idx(px_q - 3'd1, py_q);
    assign a_br_s = pix_idx(px_q,        py_q);

    assign pix_blocked_s = load | load_d_q;
    assign avg_s         = avg4(r_tl_s, r_tr_s, r_bl_s, r_br_s);

    // Counter runs through both load and write phases and parks at zero otherwise.
    always_comb begin
        if (load || !irb_rw) begin
            acnt_d = acnt_q + 6'd1;
        end else begin
            acnt_d = '0;
        end
    end

    // Operation point moves with saturation; honoured even during a load.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (cmd_en) begin
            case (cmd)
                CMD_UP:    py_d = (py_q > POS_MIN) ? py_q - 3'd1 : POS_MIN;
                CMD_DOWN:  py_d = (py_q < POS_MAX) ? py_q + 3'd1 : POS_MAX;
                CMD_LEFT:  px_d = (px_q > POS_MIN) ? px_q - 3'd1 : POS_MIN;
                CMD_RIGHT: px_d = (px_q < POS_MAX) ? px_q + 3'd1 : POS_MAX;
                default:   begin px_d = px_q; py_d = py_q; end
            endcase
        end else begin
            px_d = px_q;
            py_d = py_q;
        end
    end

    // Block update values for AVG / mirror commands.
    always_comb begin
        upd_en_s = 1'b0;
        u_tl_s   = r_tl_s;
        u_tr_s   = r_tr_s;
        u_bl_s   = r_bl_s;
        u_br_s   = r_br_s;
        if (cmd_en && !pix_blocked_s) begin
            case (cmd)
                CMD_AVG: begin
                    upd_en_s = 1'b1;
                    u_tl_s = avg_s; u_tr_s = avg_s; u_bl_s = avg_s; u_br_s = avg_s;
                end
                CMD_MIRX: begin
                    upd_en_s = 1'b1;
                    u_tl_s = r_bl_s; u_bl_s = r_tl_s; u_tr_s = r_br_s; u_br_s = r_tr_s;
                end
                CMD_MIRY: begin
                    upd_en_s = 1'b1;
                    u_tl_s = r_tr_s; u_tr_s = r_tl_s; u_bl_s = r_br_s; u_br_s = r_bl_s;
                end
                default: upd_en_s = 1'b0;
            endcase
        end else begin
            upd_en_s = 1'b0;
        end
    end

    // State registers; aprev/load_d line the write up with IROM's one-cycle latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_q     <= POS_INIT;
            py_q     <= POS_INIT;
            acnt_q   <= '0;
            aprev_q  <= '0;
            load_d_q <= 1'b0;
        end else begin
            px_q     <= px_d;
            py_q     <= py_d;
            acnt_q   <= acnt_d;
            aprev_q  <= acnt_q;
            load_d_q <= load;
        end
    end

    img_regfile u_regfile (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (load_d_q),
        .waddr_i   (aprev_q),
        .wdata_i   (IROM_Q),
        .ra0_i     (a_tl_s),
        .ra1_i     (a_tr_s),
        .ra2_i     (a_bl_s),
        .ra3_i     (a_br_s),
        .rd0_o     (r_tl_s),
        .rd1_o     (r_tr_s),
        .rd2_o     (r_bl_s),
        .rd3_o     (r_br_s),
        .upd_en_i  (upd_en_s),
        .ud0_i     (u_tl_s),
        .ud1_i     (u_tr_s),
        .ud2_i     (u_bl_s),
        .ud3_i     (u_br_s),
        .rb_addr_i (acnt_q),
        .rb_data_o (rb_data_s)
    );

    assign IROM_A = load    ? acnt_q    : {ADDR_W{1'b0}};
    assign IRB_A  = !irb_rw ? acnt_q    : {ADDR_W{1'b0}};
    assign IRB_D  = !irb_rw ? rb_data_s : {PIX_W{1'b0}};
    assign write  = cmd_en && (cmd == CMD_WRITE);

endmodule
